mem_bus_arbiter: RTL

- Shares one OBI-style memory port between the core instruction-fetch master and the core data master. Instruction-fetch is read-only.
- Sits between the core's fetch interface and LSU on one side, and the single unified instruction/data memory on the other.
- Arbitrates requests with round-robin priority and holds a selection stable until the memory grants it.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the master that issued it.

---
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch + LSU) arbiter onto one OBI-style memory port.
// Round-robin selection, stall lock, and an in-order ID FIFO for response routing.
module mem_bus_arbiter #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic                       prio_data;
    logic                       lock;
    logic                       lock_sel;
    cmd_t                       lock_cmd;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [CW-1:0]              count;

    logic full;
    logic sel_data;
    logic sel_req;
    logic grant;
    logic pop;
    logic head;
    cmd_t instr_cmd;
    cmd_t data_cmd;
    cmd_t cmd;

    always_comb begin
        full = (count == CW'(MAX_OUTSTANDING));
        if (lock)
            sel_data = lock_sel;
        else if (instr_req_i && data_req_i)
            sel_data = prio_data;
        else
            sel_data = data_req_i;
        sel_req   = sel_data ? data_req_i : instr_req_i;
        instr_cmd = {1'b0, 4'hF, instr_addr_i, 32'h0};
        data_cmd  = {data_we_i, data_be_i, data_addr_i, data_wdata_i};
        // A stalled command is replayed from the captured copy so the bus stays stable.
        cmd       = lock ? lock_cmd : (sel_data ? data_cmd : instr_cmd);
        mem_req_o = sel_req & ~full;
        grant     = mem_req_o & mem_gnt_i;
        pop       = mem_rvalid_i & (count != '0);
        head      = id_fifo[rptr];
    end

    assign mem_we_o    = cmd.we;
    assign mem_be_o    = cmd.be;
    assign mem_addr_o  = cmd.addr;
    assign mem_wdata_o = cmd.wdata;

    assign instr_gnt_o    = grant & ~sel_data;
    assign data_gnt_o     = grant & sel_data;
    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : NOP_INSTR;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_data <= 1'b1;
            lock      <= 1'b0;
            lock_sel  <= 1'b0;
            lock_cmd  <= '0;
            id_fifo   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            lock <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                lock_sel <= sel_data;
                lock_cmd <= cmd;
            end
            if (grant) begin
                id_fifo[wptr] <= sel_data;
                wptr          <= (wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr + PW'(1);
                prio_data     <= ~sel_data;
            end
            if (pop)
                rptr <= (rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr + PW'(1);
            case ({grant, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
